// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Latency: a byte accepted while idle drives the start bit from the accepting edge; frames last 10*DIV cycles.
// Backpressure: tx_ready drops while the holding register is full and rises once the held byte enters the shifter.
module uart_tx #(
   parameter int CLK_FREQ = 25_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       TXD,
   output logic       busy
);

   localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("uart_tx: clock cycles per bit (DIV) must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    shift_nxt;
   logic [7:0]    hold;
   logic          hold_full;
   logic          accept;
   logic          last_tick;
   logic          bit_adv;
   logic          load_shift;
   logic          load_hold;
   logic          txd_nxt;

   // tx_ready is the registered inverse of the holding-register occupancy
   assign hold_full = !tx_ready;
   assign accept    = tx_valid && tx_ready;
   assign last_tick = (cnt == '0);
   assign bit_adv   = (state == DATA) && last_tick;

   // The shifter is loaded from idle, or at the end of a stop bit (held byte first, else a same-cycle accept)
   assign load_shift = ((state == IDLE) && accept) ||
                       ((state == STOP) && last_tick && (hold_full || accept));
   assign load_hold  = accept && !load_shift;

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode: each state lasts DIV cycles, DATA repeats for eight bits
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = START;
         START:   if (last_tick) state_nxt = DATA;
         DATA:    if (last_tick && (bit_idx == 3'd7)) state_nxt = STOP;
         STOP:    if (last_tick) state_nxt = (hold_full || accept) ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: line level for the coming cycle, plus the busy flag
   always_comb begin
      shift_nxt = shift;
      if (load_shift)   shift_nxt = hold_full ? hold : tx_data;
      else if (bit_adv) shift_nxt = {1'b0, shift[7:1]};
      case (state_nxt)
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = shift_nxt[0];
         default: txd_nxt = 1'b1;
      endcase
      busy = (state != IDLE) || hold_full;
   end

   // Baud counter: reload on every state entry and every data-bit advance, then count down to zero
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                                cnt <= '0;
      else if ((state_nxt != state) || bit_adv) cnt <= RELOAD;
      else if (cnt != '0)                       cnt <= cnt - CW'(1);
   end

   // Data bit index, cleared whenever the shifter is outside DATA
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                  bit_idx <= 3'd0;
      else if (state_nxt != DATA) bit_idx <= 3'd0;
      else if (bit_adv)           bit_idx <= bit_idx + 3'd1;
   end

   // Shifter, holding register and its occupancy flag
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         shift    <= 8'h00;
         hold     <= 8'h00;
         tx_ready <= 1'b1;
      end else begin
         shift <= shift_nxt;
         if (load_hold) begin
            hold     <= tx_data;
            tx_ready <= 1'b0;
         end else if (load_shift && hold_full) begin
            tx_ready <= 1'b1;
         end
      end
   end

   // Registered line driver so TXD never glitches; reset forces the line idle at once
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) TXD <= 1'b1;
      else       TXD <= txd_nxt;
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at DIV=4: directed frame tables, corner sequences and a random stream.
// Outputs are sampled on the falling edge; sample k after an accepting edge N sees the state left by edge N+k-1.
// A bench receiver and an arrival-time model check the random stream.
module tb_uart_tx;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 250_000;
   localparam int NRAND    = 200;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       TXD;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;

   uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .CLK(CLK), .RESET(RESET), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .TXD(TXD), .busy(busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Checks 40 samples of a frame starting at the current sample (sample 1 of the frame).
   task automatic check_frame(input string name, input logic [9:0] fr);
      for (int k = 0; k < 40; k++) begin
         check(name, {31'd0, TXD}, {31'd0, fr[k / 4]});
         check({name, " busy"}, {31'd0, busy}, 32'd1);
         if (k < 39) @(negedge CLK);
      end
   endtask

   // Handshake from idle: valid for one edge, returns at sample 1.
   task automatic send_idle(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge CLK);
      tx_valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit k = line level during bit slot k (start, d0..d7, stop)
   } vec_t;
   vec_t vecs[6];

   // Random-phase model and receiver state
   logic [7:0] exp_data[$];
   int         exp_start[$];
   bit         rx_en = 1'b0;
   bit         rx_busy = 1'b0;
   int         rx_pos = 0;
   int         rx_t0 = 0;
   int         rx_cnt = 0;
   logic       rx_lvl = 1'b1;
   logic [9:0] rx_bits = '0;

   // Bench UART receiver: 40 samples per frame, each bit slot must be flat
   always @(negedge CLK) begin
      if (rx_en) begin
         if (!rx_busy && (TXD === 1'b0)) begin
            rx_busy = 1'b1;
            rx_pos  = 0;
            rx_t0   = edge_cnt;
         end
         if (rx_busy) begin
            if (rx_pos % 4 == 0) rx_lvl = TXD;
            else check("rx bit stable", {31'd0, TXD}, {31'd0, rx_lvl});
            if (rx_pos % 4 == 2) rx_bits[rx_pos / 4] = TXD;
            if (rx_pos == 39) begin
               check("rx start bit", {31'd0, rx_bits[0]}, 32'd0);
               check("rx stop bit", {31'd0, rx_bits[9]}, 32'd1);
               if (exp_data.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rx unexpected frame: got data %0h expected none", rx_bits[8:1]);
               end else begin
                  check("rx data", {24'd0, rx_bits[8:1]}, {24'd0, exp_data.pop_front()});
                  check("rx start edge", rx_t0, exp_start.pop_front());
               end
               rx_cnt++;
               rx_busy = 1'b0;
            end
            rx_pos++;
         end
      end
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int last_start;
      int guard;
      int acc;
      int gap;
      bit hs;
      logic [7:0] d;
      logic [9:0] fa;
      logic [9:0] fb;

      vecs[0] = '{8'h55, 10'b1_0101_0101_0};
      vecs[1] = '{8'h00, 10'b1_0000_0000_0};
      vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
      vecs[3] = '{8'h81, 10'b1_1000_0001_0};
      vecs[4] = '{8'hA3, 10'b1_1010_0011_0};
      vecs[5] = '{8'h0F, 10'b1_0000_1111_0};

      // Reset state and 100 idle cycles
      repeat (3) @(negedge CLK);
      check("reset {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
      RESET = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         check("idle {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
      end

      // Single frames from idle
      for (int i = 0; i < 6; i++) begin
         send_idle(vecs[i].data);
         check("single ready", {31'd0, tx_ready}, 32'd1);
         check_frame("single frame", vecs[i].frame);
         @(negedge CLK);
         check("single end {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
         repeat (3) @(negedge CLK);
      end

      // Back-to-back 0xA3, 0x0F with valid held high
      fa = vecs[4].frame;
      fb = vecs[5].frame;
      tx_data  = 8'hA3;
      tx_valid = 1'b1;
      @(negedge CLK);
      check("b2b ready k1", {31'd0, tx_ready}, 32'd1);
      check("b2b TXD k1", {31'd0, TXD}, 32'd0);
      tx_data = 8'h0F;
      @(negedge CLK);
      check("b2b ready k2", {31'd0, tx_ready}, 32'd0);
      tx_valid = 1'b0;
      for (int k = 2; k <= 80; k++) begin
         check("b2b TXD", {31'd0, TXD}, {31'd0, (k <= 40) ? fa[(k - 1) / 4] : fb[(k - 41) / 4]});
         check("b2b ready", {31'd0, tx_ready}, {31'd0, (k >= 41)});
         check("b2b busy", {31'd0, busy}, 32'd1);
         @(negedge CLK);
      end
      check("b2b end {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
      repeat (3) @(negedge CLK);

      // Accept 0xFF on the last stop cycle with the holding register empty
      send_idle(8'h81);
      fa = vecs[3].frame;
      for (int k = 1; k < 40; k++) begin
         check("laststop first frame", {31'd0, TXD}, {31'd0, fa[(k - 1) / 4]});
         @(negedge CLK);
      end
      check("laststop TXD k40", {31'd0, TXD}, 32'd1);
      check("laststop ready k40", {31'd0, tx_ready}, 32'd1);
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      @(negedge CLK);
      tx_valid = 1'b0;
      check("laststop no gap", {31'd0, TXD}, 32'd0);
      check("laststop ready k41", {31'd0, tx_ready}, 32'd1);
      check_frame("laststop second frame", vecs[2].frame);
      @(negedge CLK);
      check("laststop end busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge CLK);

      // Reset 17 cycles into a 0x00 frame with 0x0F held
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge CLK);
      tx_data = 8'h0F;
      @(negedge CLK);
      check("rst held ready", {31'd0, tx_ready}, 32'd0);
      tx_valid = 1'b0;
      repeat (15) @(negedge CLK);
      check("rst pre TXD", {31'd0, TXD}, 32'd0);
      RESET = 1'b1;
      #1;
      check("rst async {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         check("rst after {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
      end

      // Accept on the first edge after reset release
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      send_idle(8'h55);
      check_frame("post reset frame", vecs[0].frame);
      @(negedge CLK);
      check("post reset end busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge CLK);

      // Random stream: start of frame = max(accept edge, previous start + 40)
      rx_en = 1'b1;
      last_start = -1000;
      for (int i = 0; i < NRAND; i++) begin
         d   = 8'($urandom);
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
         if (gap > 0) begin
            tx_valid = 1'b0;
            repeat (gap) @(negedge CLK);
         end
         tx_data  = d;
         tx_valid = 1'b1;
         guard = 0;
         hs    = 1'b0;
         acc   = 0;
         while (!hs && guard <= 100) begin
            hs  = tx_ready;
            acc = edge_cnt + 1;
            @(negedge CLK);
            guard++;
         end
         if (!hs) begin
            checks++;
            failures++;
            $display("FAIL handshake timeout: byte %0d not accepted within %0d cycles", i, guard);
            break;
         end
         last_start = (acc > last_start + 40) ? acc : last_start + 40;
         exp_data.push_back(d);
         exp_start.push_back(last_start);
      end
      tx_valid = 1'b0;
      guard = 0;
      while (rx_cnt < NRAND && guard < 3000) begin
         @(negedge CLK);
         guard++;
      end
      check("rx frame count", rx_cnt, NRAND);
      repeat (5) @(negedge CLK);
      check("random end {TXD,ready,busy}", {29'd0, TXD, tx_ready, busy}, 32'b110);
      check("random leftover", exp_data.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
